// File: rtl/prog_seq.sv
// prog_seq: program sequencer that produces the fetch address for the core.
// Supports absolute branches, signed relative branches, and call/return through
// a small hardware stack. It also has a fetch stall and a sticky halt state.
//
// Parameters:
//   D           program address width (PrgCtr wraps modulo 2^D)
//   OFFW        relative-branch offset width (OFFW <= D)
//   STACK_DEPTH number of return-address entries (>= 1)
// Ports:
//   Clk, Reset  clock and synchronous active-high reset
//   Stall       freeze PrgCtr and stack for this edge
//   Halt        enter HALTED (left only by Reset)
//   BranchAbs   PrgCtr <= Target
//   BranchRel   PrgCtr <= PrgCtr + sign_extend(Offset)
//   Call        push PrgCtr+1 and jump to Target
//   Ret         pop the return address into PrgCtr
//   Target      absolute destination
//   Offset      two's-complement displacement
//   PrgCtr      current fetch address (registered)
//   Halted      high while halted (registered)
//   Depth       number of valid stack entries (registered)
//   StackErr    sticky overflow/underflow flag (registered)
module prog_seq #(
  parameter int D           = 12,
  parameter int OFFW        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               Stall,
  input  logic                               Halt,
  input  logic                               BranchAbs,
  input  logic                               BranchRel,
  input  logic                               Call,
  input  logic                               Ret,
  input  logic [D-1:0]                       Target,
  input  logic [OFFW-1:0]                    Offset,
  output logic [D-1:0]                       PrgCtr,
  output logic                               Halted,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   Depth,
  output logic                               StackErr
);

  localparam int DW = $clog2(STACK_DEPTH + 1);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [D-1:0]    pc_q, pc_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            err_q, err_d;
  logic            push_en;

  // Stack storage is deliberately not reset; only entries below depth_q are valid.
  logic [D-1:0]    stack_q [STACK_DEPTH];

  logic [D-1:0]    pc_inc;
  logic [D-1:0]    off_ext;
  logic [D-1:0]    stack_top;

  assign pc_inc  = pc_q + D'(1);
  // A signed size cast sign-extends and still works when OFFW == D.
  assign off_ext = D'($signed(Offset));

  // Top-of-stack read mux: the entry just below depth_q.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) stack_top = stack_q[i];
    end
  end

  // Per-entry write enables. The pushed return address is always pc_inc and is
  // written into the slot at the current depth.
  generate
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      always_ff @(posedge Clk) begin
        if (!Reset && push_en && (depth_q == DW'(gi))) begin
          stack_q[gi] <= pc_inc;
        end
      end
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. The if/else chain follows the strobe priority order.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (state_q == RUN) begin
      if (Halt) begin
        state_d = HALTED;
      end else if (Stall) begin
        // hold everything
      end else if (Ret) begin
        if (depth_q != '0) begin
          pc_d    = stack_top;
          depth_d = depth_q - DW'(1);
        end else begin
          err_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else if (Call) begin
        if (depth_q != DW'(STACK_DEPTH)) begin
          push_en = 1'b1;
          depth_d = depth_q + DW'(1);
          pc_d    = Target;
        end else begin
          err_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else if (BranchAbs) begin
        pc_d = Target;
      end else if (BranchRel) begin
        pc_d = pc_q + off_ext;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  assign PrgCtr   = pc_q;
  assign Halted   = (state_q == HALTED);
  assign Depth    = depth_q;
  assign StackErr = err_q;

endmodule

// File: doc/prog_seq.md
# prog_seq

Parametrised program sequencer: the next-generation program counter for the core's fetch stage. It adds several features to the basic absolute-jump counter:
- signed relative branches;
- a hardware call/return stack of configurable depth;
- a fetch stall;
- a sticky halt state.

It drives the instruction-memory address each cycle. It takes decoded control strobes from the control unit.

## Interface

- D, 12: program address width; PrgCtr wraps modulo 2^D.
- OFFW, 8: width of the signed relative-branch offset; must satisfy OFFW ≤ D.
- STACK_DEPTH, 4: number of return-address entries; must be ≥ 1.
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold PrgCtr and stack unchanged this cycle.
- Halt  in  1  enter HALTED at this edge.
- BranchAbs  in  1  PrgCtr <= Target.
- BranchRel  in  1  PrgCtr <= PrgCtr + sign_extend(Offset).
- Call  in  1  push PrgCtr+1, then PrgCtr <= Target.
- Ret  in  1  pop the top of stack into PrgCtr.
- Target  in  D  absolute jump/call destination.
- Offset  in  OFFW  two's-complement relative displacement.
- PrgCtr  out  D  current fetch address.
- Halted  out  1  high while in HALTED.
- Depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- StackErr  out  1  sticky overflow/underflow flag.

## Operation

- FSM states:
  - RUN: normal sequencing.
  - HALTED: PrgCtr, stack and Depth are frozen; all inputs except Reset are ignored. The only exit is Reset.
- Per-edge priority, evaluated in RUN: Reset > Halt > Stall > Ret > Call > BranchAbs > BranchRel > increment (PrgCtr+1).
- Halt: goes RUN→HALTED. PrgCtr holds its current value at that edge.
- Stall: holds everything. No push or pop occurs.
- Ret with Depth>0: PrgCtr <= stack[Depth-1]; Depth decrements.
- Ret with Depth==0 (underflow): StackErr <= 1; PrgCtr <= PrgCtr+1; Depth stays 0.
- Call with Depth<STACK_DEPTH: stack[Depth] <= PrgCtr+1 (mod 2^D); Depth increments; PrgCtr <= Target.
- Call with Depth==STACK_DEPTH (overflow): StackErr <= 1; no push; no jump; PrgCtr <= PrgCtr+1.
- Arithmetic:
  - Offset is sign-extended to D bits and added modulo 2^D; no saturation.
  - The increment wraps from 2^D-1 to 0.
  - A pushed return address wraps the same way.
- StackErr clears only on Reset.
- Stack entry storage is not reset. Only entries below Depth are meaningful.

## Timing

- Reset values: PrgCtr=0, Depth=0, StackErr=0, Halted=0, state=RUN.
- All outputs are registered. A strobe sampled at edge N takes effect in the values visible after edge N; the new PrgCtr is valid for the whole cycle N+1.
- There are no combinational input→output paths.
- Ret directly after Call: the pushed address is available on the next edge. Single-cycle call/return turnaround is supported.
- Simultaneous strobes resolve strictly by the priority above. Example: Call+BranchAbs acts as a Call.
- Reset asserted in any state or mid-sequence: the reset values take effect at that edge, and the stack is logically emptied.
- Halt+Stall at the same edge: the block enters HALTED.

## Test plan

- Reset held 2 cycles, then released with no strobes → PrgCtr reads 0, 1, 2, 3 on successive cycles; Halted=0, Depth=0, StackErr=0.
- PrgCtr=10:
  - BranchRel with Offset=8'hFD → next PrgCtr=7.
  - From PrgCtr=7, BranchRel with Offset=8'h05 → 12.
  - With PrgCtr=12'hFFF, no strobe → 0.
- Nested calls: PrgCtr=5, Call Target=100 → PrgCtr=100, Depth=1. Then Call Target=200 → PrgCtr=200, Depth=2. Then Ret → 101, then Ret → 6, with Depth=0 and StackErr=0.
- Overflow (STACK_DEPTH=4): five consecutive Calls → the fifth call leaves Depth=4 and gives PrgCtr=previous+1 with StackErr=1. A later Ret on empty keeps StackErr=1.
- Stall priority: Stall held 3 cycles together with BranchAbs Target=50 → PrgCtr unchanged for 3 cycles. When Stall drops, BranchAbs Target=50 takes effect.
- Halt: Halt pulsed at PrgCtr=40 → Halted=1 and PrgCtr=40 permanently, regardless of Call/Ret/BranchAbs. Reset → PrgCtr=0, Halted=0.
